// File: rtl/pulse_class_tally.sv
// Purpose: tally run-length class events per fixed-size frame and report one summary record per frame.
// Latency: the record is valid right after the edge that samples the frame-completing event.
// Backpressure: the record is held until accepted; a frame completing while a record is still held is dropped and rpt_lost sets.
module pulse_class_tally #(
    parameter int CNT_W     = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       y,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_c1,
    output logic [CNT_W-1:0] rpt_c2,
    output logic [CNT_W-1:0] rpt_c3,
    output logic             rpt_lost,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       y_q;
    logic             evt;
    logic [CNT_W-1:0] c1, c2, c3, evt_cnt;
    logic [CNT_W-1:0] b1, b2, b3, bcnt;
    logic [CNT_W-1:0] c1_inc, c2_inc, c3_inc, cnt_inc;
    logic             done;
    logic             load;

    // A held code counts once; a direct switch between nonzero codes is a new event.
    assign evt = (y != 2'b00) && (y != y_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = COUNT;
            COUNT:   if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COUNT);
    end

    // Entering COUNT starts from zero, yet the event sampled on that same edge still counts.
    always_comb begin
        b1      = (state == COUNT) ? c1 : '0;
        b2      = (state == COUNT) ? c2 : '0;
        b3      = (state == COUNT) ? c3 : '0;
        bcnt    = (state == COUNT) ? evt_cnt : '0;
        c1_inc  = b1 + CNT_W'(evt && (y == 2'b01) && (b1 != CNT_MAX));
        c2_inc  = b2 + CNT_W'(evt && (y == 2'b10) && (b2 != CNT_MAX));
        c3_inc  = b3 + CNT_W'(evt && (y == 2'b11) && (b3 != CNT_MAX));
        cnt_inc = bcnt + CNT_W'(evt);
        done    = (state == COUNT) && en && evt && (evt_cnt == LAST);
        load    = done && (!rpt_valid || rpt_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q <= 2'b00;
        end else begin
            y_q <= y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || !en || done) begin
            c1      <= '0;
            c2      <= '0;
            c3      <= '0;
            evt_cnt <= '0;
        end else begin
            c1      <= c1_inc;
            c2      <= c2_inc;
            c3      <= c3_inc;
            evt_cnt <= cnt_inc;
        end
    end

    // A completion coinciding with acceptance replaces the record without a gap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rpt_valid <= 1'b0;
            rpt_c1    <= '0;
            rpt_c2    <= '0;
            rpt_c3    <= '0;
            rpt_lost  <= 1'b0;
        end else begin
            if (load) begin
                rpt_valid <= 1'b1;
                rpt_c1    <= c1_inc;
                rpt_c2    <= c2_inc;
                rpt_c3    <= c3_inc;
            end else if (rpt_valid && rpt_ready) begin
                rpt_valid <= 1'b0;
            end
            if (done && !load) begin
                rpt_lost <= 1'b1;
            end
        end
    end

endmodule
